// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth partial-product accumulator.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_ACC_W = 2 * DEF_WIDTH;

    function automatic int unsigned rows(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned acc_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Row-side and product-side handshake bundle of the Booth accumulator.
interface booth_pp_accumulator_if
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    localparam int unsigned ACC_W = acc_width(WIDTH);

    logic             pp_valid;
    logic             pp_ready;
    logic [WIDTH:0]   pp_row;
    logic             pp_neg;
    logic             pp_last;
    logic [ACC_W-1:0] prod;
    logic             prod_valid;
    logic             prod_ready;
    logic             err;

    modport master (
        output pp_valid, pp_row, pp_neg, pp_last, prod_ready,
        input  pp_ready, prod, prod_valid, err
    );

    modport slave (
        input  pp_valid, pp_row, pp_neg, pp_last, prod_ready,
        output pp_ready, prod, prod_valid, err
    );

endinterface

// File: rtl/booth_row_align.sv
// Sign-extends one Booth row, folds in its +1 correction and shifts it to digit position k.
module booth_row_align
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned KW    = 2
) (
    input  logic [WIDTH:0]       pp_row,
    input  logic                 pp_neg,
    input  logic [KW-1:0]        k,
    output logic [2*WIDTH-1:0]   addend
);
    localparam int unsigned ACC_W = acc_width(WIDTH);

    logic [ACC_W-1:0] ext;

    always_comb begin
        ext    = {{(ACC_W-WIDTH-1){pp_row[WIDTH]}}, pp_row} + {{(ACC_W-1){1'b0}}, pp_neg};
        addend = ext << {k, 1'b0};
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates ROWS Booth partial-product rows, LSD first, and presents the signed product.
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    booth_pp_accumulator_if.slave   bus
);
    localparam int unsigned ROWS   = rows(WIDTH);
    localparam int unsigned ACC_W  = acc_width(WIDTH);
    localparam int unsigned KW     = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(ROWS - 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic             err_q, err_d;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic             ready;
    logic             accept;
    logic             last_row;

    booth_row_align #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_align (
        .pp_row (bus.pp_row),
        .pp_neg (bus.pp_neg),
        .k      (k_q),
        .addend (addend)
    );

    assign ready          = (state_q != DONE);
    assign accept         = bus.pp_valid && ready;
    assign last_row       = (k_q == LAST_K);
    assign sum            = acc_q + addend;

    assign bus.pp_ready   = ready;
    assign bus.prod_valid = (state_q == DONE);
    assign bus.prod       = prod_q;
    assign bus.err        = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    k_d   = k_q + KW'(1);
                    // row count decides completion; pp_last only flags disagreement
                    err_d = (bus.pp_last != last_row);
                    if (last_row) begin
                        state_d = DONE;
                        prod_d  = sum;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                if (bus.prod_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench: rows derived from random A,B by Booth recoding; expected product is A*B.
module tb_booth_pp_accumulator;
    import booth_pkg::*;

    localparam int unsigned W     = DEF_WIDTH;
    localparam int unsigned ROWS  = rows(W);
    localparam int unsigned ACC_W = DEF_ACC_W;

    typedef struct {
        logic [ACC_W-1:0] prod;
        int               errs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_pp_accumulator_if #(.WIDTH(W)) bus ();

    booth_pp_accumulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    int err_seen = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    logic [ACC_W-1:0] held;
    bit held_v = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream consumer and monitor share one process so ready and the handshake decision agree.
    initial begin
        exp_t e;
        bus.prod_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_cnt = 0;
                held_v   = 0;
            end else begin
                if (bus.prod_valid) done_cnt++;
                else done_cnt = 0;
                case (ready_mode)
                    0: bus.prod_ready = 1'b1;
                    1: bus.prod_ready = ($urandom_range(0, 3) != 0);
                    default: bus.prod_ready = (done_cnt > 5);
                endcase
                if (bus.err) err_seen++;
                if (bus.prod_valid) begin
                    chk("pp_ready_in_done", 32'(bus.pp_ready), 32'd0);
                    if (held_v) chk("prod_stable", 32'(bus.prod), 32'(held));
                    else begin
                        held   = bus.prod;
                        held_v = 1;
                    end
                    if (bus.prod_ready) begin
                        if (sb.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_prod: got 0x%0h expected none", bus.prod);
                        end else begin
                            e = sb.pop_front();
                            chk("prod", 32'(bus.prod), 32'(e.prod));
                            chk("err_count", err_seen, e.errs);
                        end
                        err_seen = 0;
                        held_v   = 0;
                    end
                end
            end
        end
    end

    task automatic make_rows(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                             output logic [W:0] rw [ROWS], output logic ng [ROWS]);
        for (int unsigned i = 0; i < ROWS; i++) begin
            int d, mag, bm1;
            bm1 = (i == 0) ? 0 : int'(b[2*i-1]);
            d   = -2 * int'(b[2*i+1]) + int'(b[2*i]) + bm1;
            mag = ((d < 0) ? -d : d) * int'(a);
            if (d < 0) begin
                rw[i] = ~((W+1)'(mag));
                ng[i] = 1'b1;
            end else begin
                rw[i] = (W+1)'(mag);
                ng[i] = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.pp_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_row(input logic [W:0] row, input logic neg, input logic last);
        bit acc;
        acc = 0;
        bus.pp_valid = 1'b1;
        bus.pp_row   = row;
        bus.pp_neg   = neg;
        bus.pp_last  = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.pp_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL row_accept_timeout: got no accept expected accept within 200 cycles");
        end
        bus.pp_valid = 1'b0;
    endtask

    // mode 0: correct pp_last, 1: extra pp_last on row 1, 2: pp_last omitted on final row
    task automatic product(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                           input int mode, input bit bubbles);
        logic [W:0] rw [ROWS];
        logic       ng [ROWS];
        logic       last;
        exp_t       e;
        make_rows(a, b, rw, ng);
        e.prod = ACC_W'(int'(a) * int'(b));
        e.errs = (mode != 0) ? 1 : 0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            last = (i == ROWS - 1);
            if (mode == 1 && i == 1) last = 1'b1;
            if (mode == 2 && i == ROWS - 1) last = 1'b0;
            if (i == ROWS - 1) sb.push_back(e);
            send_row(rw[i], ng[i], last);
            if (i == ROWS - 1) chk("prod_valid_latency", 32'(bus.prod_valid), 32'd1);
            if (bubbles && $urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pp_ready"},   32'(bus.pp_ready),   32'd1);
        chk({tag, "_prod_valid"}, 32'(bus.prod_valid), 32'd0);
        chk({tag, "_err"},        32'(bus.err),        32'd0);
        chk({tag, "_prod"},       32'(bus.prod),       32'd0);
    endtask

    initial begin
        logic signed [W-1:0] ra, rb;
        logic [W:0] rw [ROWS];
        logic       ng [ROWS];
        int         waited;

        bus.pp_valid = 1'b0;
        bus.pp_row   = '0;
        bus.pp_neg   = 1'b0;
        bus.pp_last  = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        ready_mode = 0;
        product(-8'sd3, 8'sd5, 0, 0);
        product(8'sd7, -8'sd1, 0, 0);
        product(-8'sd128, -8'sd128, 0, 0);

        ready_mode = 2;
        repeat (4) begin
            ra = W'($urandom);
            rb = W'($urandom);
            product(ra, rb, 0, 1);
        end

        ready_mode = 1;
        repeat (40) begin
            ra = W'($urandom);
            rb = W'($urandom);
            product(ra, rb, 0, bit'($urandom_range(0, 1)));
        end

        ready_mode = 0;
        ra = W'($urandom);
        rb = W'($urandom);
        product(ra, rb, 1, 0);
        ra = W'($urandom);
        rb = W'($urandom);
        product(ra, rb, 2, 1);

        product(8'sd100, -8'sd77, 0, 0);
        make_rows(8'sd45, -8'sd99, rw, ng);
        send_row(rw[0], ng[0], 1'b0);
        send_row(rw[1], ng[1], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        err_seen = 0;
        rst_n = 1'b1;

        product(-8'sd3, 8'sd5, 0, 0);
        ra = W'($urandom);
        rb = W'($urandom);
        product(ra, rb, 0, 1);

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending products expected 0", sb.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
